switch_reader: RTL and testbench

Memory-mapped input peripheral: the read-side counterpart to the LED output register. It synchronises and debounces the board's 24 slide switches and 5 push buttons, and records button presses in sticky flags. It returns switch and button state to the CPU on a single-cycle-latency read port. It sits on the same peripheral bus as the LED register; the bus decoder drives `ren`/`sel`.

---
 rtl/switch_reader_pkg.sv | 15 +
 rtl/input_debouncer.sv | 49 ++++
 rtl/switch_reader.sv | 81 ++++++++
 tb/tb_switch_reader.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/switch_reader_pkg.sv
// Shared constants for the switch/button read peripheral: register select
// encoding, BUTTON word field positions and default input widths.
package switch_reader_pkg;

  typedef enum logic {
    SEL_SWITCH = 1'b0,
    SEL_BUTTON = 1'b1
  } sel_e;

  localparam int unsigned SW_W          = 24;
  localparam int unsigned BTN_W         = 5;
  localparam int unsigned BTN_STATE_LSB = 0;
  localparam int unsigned BTN_FLAG_LSB  = 8;

endpackage

// File: rtl/input_debouncer.sv
// Per-bit two-flop synchroniser plus tick-sampled 3-of-3 debounce filter.
// rise pulses for one cycle, aligned with the updated d, on a 0->1 change.
module input_debouncer #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic [W-1:0] raw,
  output logic [W-1:0] d,
  output logic [W-1:0] rise
);
  import switch_reader_pkg::*;

  logic [W-1:0] sync1;
  logic [W-1:0] s;
  logic [W-1:0] h0;
  logic [W-1:0] h1;
  logic [W-1:0] agree;
  logic [W-1:0] d_next;

  // A bit follows s only when the current sample and both held samples agree.
  always_comb begin
    agree  = ~(s ^ h0) & ~(s ^ h1);
    d_next = (agree & s) | (~agree & d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      s     <= '0;
      h0    <= '0;
      h1    <= '0;
      d     <= '0;
      rise  <= '0;
    end else begin
      sync1 <= raw;
      s     <= sync1;
      rise  <= '0;
      if (tick) begin
        h0   <= s;
        h1   <= h0;
        d    <= d_next;
        rise <= d_next & ~d;
      end
    end
  end

endmodule

// File: rtl/switch_reader.sv
// Memory-mapped switch/button reader: debounced inputs, sticky press flags,
// one-cycle-latency read port and a level interrupt from the flags.
module switch_reader #(
  parameter int unsigned SW_W     = switch_reader_pkg::SW_W,
  parameter int unsigned BTN_W    = switch_reader_pkg::BTN_W,
  parameter int unsigned TICK_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SW_W-1:0]   sw,
  input  logic [BTN_W-1:0]  btn,
  input  logic              ren,
  input  logic              sel,
  output logic [31:0]       rdata,
  output logic              rvalid,
  output logic              irq
);
  import switch_reader_pkg::*;

  localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] cnt;
  logic             tick;
  logic [SW_W-1:0]  sw_d;
  logic [SW_W-1:0]  sw_rise;
  logic [BTN_W-1:0] btn_d;
  logic [BTN_W-1:0] press;
  logic [BTN_W-1:0] flag;
  logic             clr;
  logic [31:0]      rword;

  input_debouncer #(.W(SW_W)) u_sw_deb (
    .clk  (clk),
    .rst  (rst),
    .tick (tick),
    .raw  (sw),
    .d    (sw_d),
    .rise (sw_rise)
  );

  input_debouncer #(.W(BTN_W)) u_btn_deb (
    .clk  (clk),
    .rst  (rst),
    .tick (tick),
    .raw  (btn),
    .d    (btn_d),
    .rise (press)
  );

  always_comb begin
    tick  = (cnt == CNT_W'(TICK_DIV - 1));
    clr   = ren && (sel == SEL_BUTTON);
    irq   = |flag;
    rword = '0;
    if (sel == SEL_BUTTON) begin
      rword[BTN_STATE_LSB +: BTN_W] = btn_d;
      rword[BTN_FLAG_LSB  +: BTN_W] = flag;
    end else begin
      rword[SW_W-1:0] = sw_d;
    end
  end

  // rword samples flag before this edge's update, so a colliding read sees
  // the pre-set value while the press still wins in flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      flag   <= '0;
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      cnt    <= tick ? '0 : cnt + 1'b1;
      flag   <= (flag & ~{BTN_W{clr}}) | press;
      rvalid <= ren;
      if (ren) begin
        rdata <= rword;
      end
    end
  end

endmodule

// File: tb/tb_switch_reader.sv
// Scoreboard bench for switch_reader: a per-edge behavioural model pushes
// expected read words; a negedge monitor pops and compares them.
module tb_switch_reader;
  localparam int unsigned TD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] sw;
  logic [4:0]  btn;
  logic        ren;
  logic        sel;
  logic [31:0] rdata;
  logic        rvalid;
  logic        irq;

  always #5 clk = ~clk;

  switch_reader #(.SW_W(24), .BTN_W(5), .TICK_DIV(TD)) dut (
    .clk    (clk),
    .rst    (rst),
    .sw     (sw),
    .btn    (btn),
    .ren    (ren),
    .sel    (sel),
    .rdata  (rdata),
    .rvalid (rvalid),
    .irq    (irq)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [23:0] sw_hist[$];
  logic [4:0]  btn_hist[$];
  logic [23:0] sw_smp[$];
  logic [4:0]  btn_smp[$];
  logic [23:0] m_sw_d;
  logic [4:0]  m_btn_d;
  logic [4:0]  m_flag;
  logic [4:0]  m_pend;
  logic [31:0] m_last;
  logic [31:0] exp_q[$];
  int unsigned m_edge;
  logic [23:0] sw_s, sa, sb, sc;
  logic [4:0]  btn_s, ba, bb, bc, new_bd;

  function automatic logic [31:0] ref_word(input logic s, input logic [23:0] swd,
                                           input logic [4:0] bd, input logic [4:0] fl);
    if (s) return {19'h0, fl, 3'h0, bd};
    return {8'h0, swd};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      sw_hist  = '{24'h0, 24'h0};
      btn_hist = '{5'h0, 5'h0};
      sw_smp   = '{24'h0, 24'h0, 24'h0};
      btn_smp  = '{5'h0, 5'h0, 5'h0};
      m_sw_d = '0; m_btn_d = '0; m_flag = '0; m_pend = '0; m_last = '0;
      m_edge = 0;
      exp_q.delete();
    end else begin
      m_edge++;
      if (ren) begin
        m_last = ref_word(sel, m_sw_d, m_btn_d, m_flag);
        exp_q.push_back(m_last);
      end
      m_flag = (ren && sel) ? m_pend : (m_flag | m_pend);
      m_pend = '0;
      // s seen at this edge is the pin value from two edges earlier
      sw_s  = sw_hist.pop_front();  sw_hist.push_back(sw);
      btn_s = btn_hist.pop_front(); btn_hist.push_back(btn);
      if (m_edge % TD == 0) begin
        void'(sw_smp.pop_front());  sw_smp.push_back(sw_s);
        void'(btn_smp.pop_front()); btn_smp.push_back(btn_s);
        sa = sw_smp[0]; sb = sw_smp[1]; sc = sw_smp[2];
        ba = btn_smp[0]; bb = btn_smp[1]; bc = btn_smp[2];
        for (int i = 0; i < 24; i++)
          if (sa[i] == sb[i] && sb[i] == sc[i]) m_sw_d[i] = sc[i];
        new_bd = m_btn_d;
        for (int i = 0; i < 5; i++)
          if (ba[i] == bb[i] && bb[i] == bc[i]) new_bd[i] = bc[i];
        m_pend  = new_bd & ~m_btn_d;
        m_btn_d = new_bd;
      end
    end
  end

  // ---------------- monitor ----------------
  logic [31:0] exp_word;
  always @(negedge clk) begin
    check("irq", 32'(irq), 32'(|m_flag));
    check("rvalid", 32'(rvalid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      exp_word = exp_q.pop_front();
      if (rvalid) check("rdata", rdata, exp_word);
    end else if (!rvalid) begin
      check("rdata_hold", rdata, m_last);
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_read(input logic s, output logic [31:0] got, output logic v);
    ren = 1'b1;
    sel = s;
    @(negedge clk);
    ren = 1'b0;
    got = rdata;
    v   = rvalid;
  endtask

  logic [31:0] got;
  logic        v;

  initial begin
    rst = 1'b1; ren = 1'b0; sel = 1'b0; sw = 24'hFFFFFF; btn = '0;
    repeat (3) @(negedge clk);
    check("reset_rdata", rdata, 32'h0);
    check("reset_rvalid", 32'(rvalid), 32'h0);
    check("reset_irq", 32'(irq), 32'h0);
    rst = 1'b0;
    do_read(1'b0, got, v);
    check("post_reset_read", got, 32'h0);
    check("post_reset_rvalid", 32'(v), 32'h1);

    sw = 24'hA5A5A5;
    repeat (16) @(negedge clk);
    do_read(1'b0, got, v);
    check("switch_read", got, 32'h00A5A5A5);
    check("switch_rvalid", 32'(v), 32'h1);

    sw = 24'h0;
    repeat (20) @(negedge clk);
    sw = 24'h000001;
    repeat (5) @(negedge clk);
    sw = 24'h0;
    repeat (20) @(negedge clk);
    do_read(1'b0, got, v);
    check("glitch_reject", got, 32'h0);

    btn = 5'b00100;
    for (int i = 0; i < 40 && !irq; i++) @(negedge clk);
    check("press_irq", 32'(irq), 32'h1);
    do_read(1'b1, got, v);
    check("button_read1", got, 32'h00000404);
    do_read(1'b1, got, v);
    check("button_read2", got, 32'h00000004);
    check("irq_cleared", 32'(irq), 32'h0);

    btn = 5'b00110;
    for (int i = 0; i < 40 && !m_pend[1]; i++) @(negedge clk);
    check("collision_window", 32'(m_pend[1]), 32'h1);
    do_read(1'b1, got, v);
    check("collision_bit9", 32'(got[9]), 32'h0);
    check("collision_word", got, 32'h00000006);
    check("collision_irq", 32'(irq), 32'h1);

    rst = 1'b1; ren = 1'b1; sel = 1'b1;
    @(negedge clk);
    rst = 1'b0; ren = 1'b0;
    check("rst_read_rvalid", 32'(rvalid), 32'h0);
    check("rst_read_irq", 32'(irq), 32'h0);
    check("rst_read_rdata", rdata, 32'h0);

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 15) == 0) sw = 24'($urandom);
      if ($urandom_range(0, 15) == 0) btn = btn ^ 5'(1 << $urandom_range(0, 4));
      ren = ($urandom_range(0, 2) == 0);
      sel = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 499) == 0);
      @(negedge clk);
    end
    rst = 1'b0; ren = 1'b0;
    repeat (5) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
